radix4_booth_seq_mul: RTL

Iterative, parametrised radix-4 Booth multiplier for the Posit FMAU mantissa datapath. It retires one Booth digit per clock into a registered accumulator, so a WIDTH×WIDTH multiply takes WIDTH/2+1 cycles at the area cost of a single partial-product generator plus an adder. It supports signed and unsigned operands per transaction. Upstream and downstream connect through valid/ready handshakes.

---
 rtl/radix4_booth_seq_mul.sv | 139 +++++++++++++
 1 files changed

// File: rtl/radix4_booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock into a registered
// accumulator, with valid/ready handshakes on operand input and product output.
module radix4_booth_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned W2     = WIDTH + 2;
  localparam int unsigned ACC_W  = 2 * W2;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned DIGITS = W2 / 2;
  localparam int unsigned CNT_W  = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [W2-1:0]       a_q, a_d;
  logic [W2-1:0]       b_q, b_d;
  logic                bm1_q, bm1_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [W2-1:0]       a_in_ext;
  logic [W2-1:0]       b_in_ext;
  logic [ACC_W-1:0]    a_wide;
  logic [ACC_W-1:0]    pp;
  logic [ACC_W-1:0]    acc_sum;

  // Operand extension to W2 bits; the extra two bits make unsigned operands
  // behave as positive signed values for Booth recoding.
  always_comb begin
    a_in_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_in_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  end

  // B is shifted right two bits per digit, so the live triplet is always at the bottom.
  always_comb begin
    a_wide = {{W2{a_q[W2-1]}}, a_q};
    case ({b_q[1:0], bm1_q})
      3'b001, 3'b010: pp = a_wide;
      3'b011:         pp = a_wide << 1;
      3'b100:         pp = -(a_wide << 1);
      3'b101, 3'b110: pp = -a_wide;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + (pp << {cnt_q, 1'b0});
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    bm1_d     = bm1_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_in_ext;
          b_d     = b_in_ext;
          bm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d = acc_sum;
        b_d   = b_q >> 2;
        bm1_d = b_q[1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          cnt_d     = '0;
          product_d = acc_sum[PROD_W-1:0];
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      bm1_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      bm1_q       <= bm1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
